notnot_round_controller: RTL
============================

Name: notnot_round_controller

Overview:
Game-sequencing stage directly upstream of text_display. Generates each NotNot round's prompt selectors and the draw_enable/start/lose/black commands, and waits on the display's done flags. Times the player's response, judges key presses, keeps score, and runs the start/lose screens.

Parameters:
ROUND_CYCLES, 100000000, response window in clocks (2 s at 50 MHz); width 32
LFSR_SEED, 16'hACE1, LFSR reset value; a value of 0 is replaced by 16'hACE1
ROUND_STEP, 5000000, window decrement per correct round (SPEEDUP_EN only)
ROUND_MIN, 25000000, window floor (SPEEDUP_EN only)

Ports:
clock  in  1  system clock
resetn  in  1  synchronous active-low reset
start_btn  in  1  start/restart button, active-high, already synchronised
keys  in  4  answer keys, active-high, synchronised; [0]=red [1]=green [2]=blue [3]=yellow
done_draw  in  1  text_display done flag; level, sticky
done_draw_black  in  1  text_display black-clear done flag; level, sticky
draw_enable  out  1  one-cycle pulse: draw the round prompt
start  out  1  one-cycle pulse: draw the start screen
lose  out  1  one-cycle pulse: draw the lose screen
black  out  1  one-cycle pulse: clear the screen
not_not_selector  out  3  prompt NOT count 0..3; bit2 always 0
colour_logic_selector  out  3  0=single, 1=OR, 2=AND, 3=single; bit2 always 0
colour_selector_1  out  3  c1 index: 0=red 1=green 2=blue 3=yellow; bit2 always 0
colour_selector_2  out  3  as displayed: 3=red 2=green 1=blue 0=yellow; bit2 always 0
score  out  8  correct rounds this game; saturates at 255
playing  out  1  high in S_PLAY only

Behaviour:
- Reset (resetn=0 at a clock edge): every output 0, LFSR=seed, timer=0, edge registers=0, state=S_BOOT. Reset mid-operation aborts immediately; text_display shares resetn.
- done_draw and done_draw_black stay high until the next prompt draw, so only their rising edges are used.
- start_btn and keys are also edge-detected: new = in & ~in_q, with the _q registers updated every cycle. A key held across rounds never counts.
- LFSR: 16-bit Galois, mask 16'hB400, advances every cycle from reset.
- All command outputs are registered. Each is high for exactly one cycle on entry to its state.
- States:
  - S_BOOT: pulse start -> S_WAIT_START.
  - S_WAIT_START: on a start_btn edge, score=0 -> S_CLEAR.
  - S_CLEAR: pulse black; on a done_draw_black rising edge -> S_GEN.
  - S_GEN, 1 cycle: latch LFSR[1:0]->not_not, [3:2]->logic, [5:4]->c1, [7:6]->sel2 -> S_DRAW.
  - S_DRAW: pulse draw_enable; keys ignored; on a done_draw rising edge, timer=window -> S_PLAY.
  - S_PLAY: timer decrements each cycle; the outcome is judged every cycle.
  - S_NEXT, 1 cycle: score+1 (saturating) -> S_GEN.
  - S_LOSE: pulse lose; on a start_btn edge, score=0 -> S_CLEAR.
- Selectors hold stable from S_GEN until the next S_GEN; text_display reads them continuously.
- Answer mask, combinational from the latched selectors:
  - c2 = ~sel2[1:0].
  - logic 0 or 3: m = onehot(c1).
  - logic 1: m = onehot(c1) | onehot(c2).
  - logic 2: m = (c1==c2) ? onehot(c1) : 4'b0000.
  - NOT count odd: m = ~m.
- S_PLAY judging, in priority order:
  1. More than one new key edge in a cycle -> S_LOSE.
  2. Exactly one new key edge k: (k & m) != 0 -> S_NEXT, else S_LOSE.
  3. Timer == 0 with no edge: m == 0 -> S_NEXT, else S_LOSE.
- A key edge on the same cycle the timer reaches 0 is judged as a press.
- start_btn is ignored outside S_WAIT_START and S_LOSE.

Optional Feature:
SPEEDUP_EN.
- Defined: the window starts at ROUND_CYCLES on each game start. Each S_NEXT reduces it by ROUND_STEP, clamped to ROUND_MIN (never below it, no underflow).
- Undefined: the window is fixed at ROUND_CYCLES and the ROUND_STEP/ROUND_MIN logic is absent.

Test Plan:
- Reset then release -> start pulse exactly 1 cycle after release; then idle until start_btn. A start_btn edge -> one black pulse; after a done_draw_black edge -> GEN -> one draw_enable pulse.
- ROUND_CYCLES=20, forced selectors not=0 logic=0 c1=2: key[2] edge in S_PLAY -> score 0->1 and a new draw_enable; key[0] -> lose pulse, score holds.
- not=1 logic=1 c1=0 sel2=2 (mask 4'b1100): key[3] -> correct; key[1] -> lose.
- logic=2 c1=0 sel2=0 (mask 0): no key -> correct exactly 20 cycles after entering S_PLAY. Same prompt with not=1: any single key -> correct. Keys 4'b0011 together -> lose.
- Key held from S_DRAW into S_PLAY -> no judgement; at timeout, lose (nonzero mask). Reset asserted mid-S_DRAW -> all outputs 0 next cycle.
- SPEEDUP_EN, ROUND_CYCLES=20, ROUND_STEP=6, ROUND_MIN=8: successive windows 20, 14, 8, 8; score 255 plus a correct round -> score stays 255.

Source files
------------

// File: rtl/notnot_round_controller_if.sv
// Display-side command/status bundle between notnot_round_controller (master)
// and text_display (slave).
interface notnot_round_controller_if;
  logic       draw_enable;
  logic       start;
  logic       lose;
  logic       black;
  logic [2:0] not_not_selector;
  logic [2:0] colour_logic_selector;
  logic [2:0] colour_selector_1;
  logic [2:0] colour_selector_2;
  logic       done_draw;
  logic       done_draw_black;

  modport master (
    output draw_enable, start, lose, black,
    output not_not_selector, colour_logic_selector, colour_selector_1, colour_selector_2,
    input  done_draw, done_draw_black
  );

  modport slave (
    input  draw_enable, start, lose, black,
    input  not_not_selector, colour_logic_selector, colour_selector_1, colour_selector_2,
    output done_draw, done_draw_black
  );
endinterface

// File: rtl/notnot_round_controller.sv
// NotNot round sequencer: prompts, response timing, judging and score.
// Optional SPEEDUP_EN shrinks the response window after every correct round.
module notnot_round_controller #(
  parameter logic [31:0] ROUND_CYCLES = 32'd100000000,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
`ifdef SPEEDUP_EN
  ,
  parameter logic [31:0] ROUND_STEP   = 32'd5000000,
  parameter logic [31:0] ROUND_MIN    = 32'd25000000
`endif
) (
  input  logic                                clock,
  input  logic                                resetn,
  input  logic                                start_btn,
  input  logic [3:0]                          keys,
  notnot_round_controller_if.master           disp,
  output logic [7:0]                          score,
  output logic                                playing
);

  typedef enum logic [2:0] {
    S_BOOT, S_WAIT_START, S_CLEAR, S_GEN, S_DRAW, S_PLAY, S_NEXT, S_LOSE
  } state_t;

  localparam logic [15:0] SEED = (LFSR_SEED == 16'h0000) ? 16'hACE1 : LFSR_SEED;

  state_t      state, state_nx;
  logic [15:0] lfsr;
  logic [31:0] timer;
  logic [31:0] window;
  logic        start_q, done_draw_q, done_black_q;
  logic [3:0]  keys_q;
  logic [1:0]  not_cnt, logic_sel, c1_idx, sel2;

  logic        start_new, draw_new, black_new, game_start;
  logic [3:0]  key_new;
  logic [3:0]  answer_mask;

  assign start_new  = start_btn & ~start_q;
  assign draw_new   = disp.done_draw & ~done_draw_q;
  assign black_new  = disp.done_draw_black & ~done_black_q;
  assign key_new    = keys & ~keys_q;
  assign game_start = (state_nx == S_CLEAR) && (state != S_CLEAR);

  assign disp.not_not_selector      = {1'b0, not_cnt};
  assign disp.colour_logic_selector = {1'b0, logic_sel};
  assign disp.colour_selector_1     = {1'b0, c1_idx};
  assign disp.colour_selector_2     = {1'b0, sel2};

  // Keys that make the round correct; sel2 is stored in displayed (inverted) order.
  always_comb begin
    logic [1:0] c2;
    logic [3:0] oh1, oh2, base;
    c2  = ~sel2;
    oh1 = 4'b0001 << c1_idx;
    oh2 = 4'b0001 << c2;
    unique case (logic_sel)
      2'd1:    base = oh1 | oh2;
      2'd2:    base = (c1_idx == c2) ? oh1 : 4'b0000;
      default: base = oh1;
    endcase
    answer_mask = not_cnt[0] ? ~base : base;
  end

  // NOTE: every output of a combinational block gets a default first; a path
  // that leaves one unassigned would infer a latch.
  always_comb begin
    state_nx = state;
    unique case (state)
      S_BOOT:       state_nx = S_WAIT_START;
      S_WAIT_START: if (start_new) state_nx = S_CLEAR;
      S_CLEAR:      if (black_new) state_nx = S_GEN;
      S_GEN:        state_nx = S_DRAW;
      S_DRAW:       if (draw_new)  state_nx = S_PLAY;
      S_PLAY: begin
        if ((key_new & (key_new - 4'd1)) != 4'd0)
          state_nx = S_LOSE;
        else if (key_new != 4'd0)
          state_nx = ((key_new & answer_mask) != 4'd0) ? S_NEXT : S_LOSE;
        else if (timer == 32'd0)
          state_nx = (answer_mask == 4'd0) ? S_NEXT : S_LOSE;
      end
      S_NEXT:       state_nx = S_GEN;
      S_LOSE:       if (start_new) state_nx = S_CLEAR;
      default:      state_nx = S_BOOT;
    endcase
  end

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state            <= S_BOOT;
      lfsr             <= SEED;
      timer            <= 32'd0;
      start_q          <= 1'b0;
      done_draw_q      <= 1'b0;
      done_black_q     <= 1'b0;
      keys_q           <= 4'd0;
      not_cnt          <= 2'd0;
      logic_sel        <= 2'd0;
      c1_idx           <= 2'd0;
      sel2             <= 2'd0;
      disp.draw_enable <= 1'b0;
      disp.start       <= 1'b0;
      disp.lose        <= 1'b0;
      disp.black       <= 1'b0;
      score            <= 8'd0;
      playing          <= 1'b0;
    end else begin
      state        <= state_nx;
      lfsr         <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
      start_q      <= start_btn;
      done_draw_q  <= disp.done_draw;
      done_black_q <= disp.done_draw_black;
      keys_q       <= keys;

      // Command pulses fire on the cycle the state is entered.
      disp.start       <= (state == S_BOOT);
      disp.black       <= game_start;
      disp.draw_enable <= (state_nx == S_DRAW) && (state != S_DRAW);
      disp.lose        <= (state_nx == S_LOSE) && (state != S_LOSE);
      playing          <= (state_nx == S_PLAY);

      if (state == S_GEN) begin
        not_cnt   <= lfsr[1:0];
        logic_sel <= lfsr[3:2];
        c1_idx    <= lfsr[5:4];
        sel2      <= lfsr[7:6];
      end

      if (state == S_DRAW && state_nx == S_PLAY)
        timer <= window;
      else if (state == S_PLAY && timer != 32'd0)
        timer <= timer - 32'd1;

      if (game_start)
        score <= 8'd0;
      else if (state == S_NEXT && score != 8'hFF)
        score <= score + 8'd1;
    end
  end

`ifdef SPEEDUP_EN
  always_ff @(posedge clock) begin
    if (!resetn || game_start)
      window <= ROUND_CYCLES;
    else if (state == S_NEXT)
      window <= (window >= ROUND_MIN && (window - ROUND_MIN) >= ROUND_STEP)
                ? window - ROUND_STEP : ROUND_MIN;
  end
`else
  assign window = ROUND_CYCLES;
`endif

endmodule
